pipe_hazard_ctrl: RTL and testbench

- Central hazard controller for the 5-stage pipeline.
- Generates the per-cycle control of the PC and pipeline registers:
  - PC write enable
  - IF/ID hold and flush
  - ID/EX and EX/MEM bubble/flush
- Sources: load-use hazards, taken branches, and a multi-cycle mul/div unit.
- Sits beside the ID stage; its outputs drive the flush/hold inputs of the pipe registers directly.
- Also keeps saturating stall/flush event counters for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline.
// Produces PC write enable, IF/ID hold/flush and ID/EX, EX/MEM bubble
// controls from load-use hazards, taken branches and the mul/div unit.
// Control outputs are Mealy (same-cycle) from the registered state and the
// live inputs; state, mul/div wait counter, perf counters and the sticky
// timeout flag are registered.
module pipe_hazard_ctrl #(
  parameter int CNT_W      = 16,
  parameter int MD_TIMEOUT = 32   // legal range 2..255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_rs_i,
  input  logic [4:0]       IFID_rt_i,
  input  logic             IFID_uses_rt_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_rt_i,
  input  logic             branch_taken_i,
  input  logic             md_start_i,
  input  logic             md_done_i,
  output logic             PC_Write_o,
  output logic             IF_Write_o,
  output logic             IF_flush_o,
  output logic             ID_flush_o,
  output logic             EX_flush_o,
  output logic             md_abort_o,
  output logic             md_err_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MD_WAIT = 2'd1
  } state_t;

  localparam int              MD_W    = $clog2(MD_TIMEOUT);
  localparam logic [MD_W-1:0] MD_LAST = MD_W'(MD_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [MD_W-1:0]    md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               md_err_q, md_err_d;
  logic               do_stall;
  logic               do_flush;
  logic               abort;
  logic               lu;

  // Load in EX whose destination feeds a source of the instruction in ID.
  // Register 0 never creates a dependency.
  assign lu = IDEX_MemRead_i && (IDEX_rt_i != 5'd0) &&
              ((IDEX_rt_i == IFID_rs_i) ||
               (IFID_uses_rt_i && (IDEX_rt_i == IFID_rt_i)));

  // Next-state logic and selection of the NORMAL / STALL / FLUSH group.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    md_err_d = md_err_q;
    do_stall = 1'b0;
    do_flush = 1'b0;
    abort    = 1'b0;
    case (state_q)
      S_RUN: begin
        if (branch_taken_i) begin
          do_flush = 1'b1;
        end else if (lu) begin
          // The bubble injected into ID/EX removes the hazard next cycle.
          do_stall = 1'b1;
        end else if (md_start_i) begin
          state_d  = S_MD_WAIT;
          md_cnt_d = '0;
        end
      end
      S_MD_WAIT: begin
        if (branch_taken_i) begin
          do_flush = 1'b1;
          abort    = 1'b1;
          state_d  = S_RUN;
        end else if (md_done_i) begin
          // EX holds a bubble while waiting, so lu cannot be live here.
          if (md_start_i) begin
            md_cnt_d = '0;
          end else begin
            state_d = S_RUN;
          end
        end else if (md_cnt_q == MD_LAST) begin
          do_stall = 1'b1;
          md_err_d = 1'b1;
          state_d  = S_RUN;
        end else begin
          do_stall = 1'b1;
          md_cnt_d = md_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // Saturating performance counters, at most one step per cycle.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (do_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (do_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // Pipe-register controls; reset forces everything to flush and freezes the PC.
  always_comb begin
    PC_Write_o = 1'b1;
    IF_Write_o = 1'b0;
    IF_flush_o = 1'b0;
    ID_flush_o = 1'b0;
    EX_flush_o = 1'b0;
    md_abort_o = 1'b0;
    if (rst_i) begin
      PC_Write_o = 1'b0;
      IF_flush_o = 1'b1;
      ID_flush_o = 1'b1;
      EX_flush_o = 1'b1;
    end else if (do_flush) begin
      IF_flush_o = 1'b1;
      ID_flush_o = 1'b1;
      EX_flush_o = 1'b1;
      md_abort_o = abort;
    end else if (do_stall) begin
      PC_Write_o = 1'b0;
      IF_Write_o = 1'b1;
      ID_flush_o = 1'b1;
    end
  end

  // State, wait counter, perf counters and sticky error register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_RUN;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      md_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      md_err_q    <= md_err_d;
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign md_err_o    = md_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl with a small timeout and narrow counters so
// the timeout and saturation corners are reachable in a short run.
// Control vector layout: {PC_Write, IF_Write, IF_flush, ID_flush, EX_flush, md_abort}.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int MD_TO = 4;

  localparam logic [5:0] NORM_V  = 6'b100000;
  localparam logic [5:0] STALL_V = 6'b010100;
  localparam logic [5:0] FLUSH_V = 6'b101110;
  localparam logic [5:0] ABORT_V = 6'b101111;
  localparam logic [5:0] RST_V   = 6'b001110;

  logic             clk;
  logic             rst;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic             idex_mem_read;
  logic [4:0]       idex_rt;
  logic             branch_taken;
  logic             md_start;
  logic             md_done;
  logic             pc_write;
  logic             if_write;
  logic             if_flush;
  logic             id_flush;
  logic             ex_flush;
  logic             md_abort;
  logic             md_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic [5:0] exp_q[$];
  int         total;
  int         bad;
  int         exp_stall;
  int         exp_flush;
  int         exp_state;
  int         exp_err;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MD_TIMEOUT(MD_TO)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .IFID_rs_i      (ifid_rs),
    .IFID_rt_i      (ifid_rt),
    .IFID_uses_rt_i (ifid_uses_rt),
    .IDEX_MemRead_i (idex_mem_read),
    .IDEX_rt_i      (idex_rt),
    .branch_taken_i (branch_taken),
    .md_start_i     (md_start),
    .md_done_i      (md_done),
    .PC_Write_o     (pc_write),
    .IF_Write_o     (if_write),
    .IF_flush_o     (if_flush),
    .ID_flush_o     (id_flush),
    .EX_flush_o     (ex_flush),
    .md_abort_o     (md_abort),
    .md_err_o       (md_err),
    .state_o        (state),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [5:0] ctrl_vec();
    return {pc_write, if_write, if_flush, id_flush, ex_flush, md_abort};
  endfunction

  task automatic check_regs(input string tag);
    check_val({tag, ".state"}, 32'(state), 32'(exp_state));
    check_val({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    check_val({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
    check_val({tag, ".md_err"}, 32'(md_err), 32'(exp_err));
  endtask

  // driver: one clock of stimulus; called at posedge+1
  task automatic cyc(input string tag, input logic mr, input logic [4:0] exrt,
                     input logic [4:0] rsv, input logic [4:0] rtv, input logic ut,
                     input logic br, input logic ms, input logic md,
                     input logic [5:0] want, input int nxt_state);
    logic [5:0] e;
    idex_mem_read = mr;
    idex_rt       = exrt;
    ifid_rs       = rsv;
    ifid_rt       = rtv;
    ifid_uses_rt  = ut;
    branch_taken  = br;
    md_start      = ms;
    md_done       = md;
    exp_q.push_back(want);
    @(negedge clk);
    e = exp_q.pop_front();
    check_val({tag, ".ctrl"}, 32'(ctrl_vec()), 32'(e));
    if (e == STALL_V && exp_stall < 15) exp_stall++;
    if ((e == FLUSH_V || e == ABORT_V) && exp_flush < 15) exp_flush++;
    @(posedge clk);
    #1;
    exp_state = nxt_state;
    check_regs(tag);
  endtask

  task automatic idle(input string tag, input logic [5:0] want, input int nxt_state);
    cyc(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, want, nxt_state);
  endtask

  initial begin
    total = 0; bad = 0;
    exp_stall = 0; exp_flush = 0; exp_state = 0; exp_err = 0;
    rst = 1'b1;
    ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
    idex_mem_read = 1'b0; idex_rt = 5'd0;
    branch_taken = 1'b0; md_start = 1'b0; md_done = 1'b0;

    // reset state
    @(negedge clk);
    check_val("rst.ctrl", 32'(ctrl_vec()), 32'(RST_V));
    check_regs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // load-use via rs: one stall, then normal
    cyc("lu_rs", 1'b1, 5'd2, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, STALL_V, 0);
    idle("lu_rs_after", NORM_V, 0);
    // load-use via rt only when rt is a source
    cyc("lu_rt", 1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, STALL_V, 0);
    cyc("lu_rt_unused", 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, NORM_V, 0);
    // register 0 never hazards; a non-load never hazards
    cyc("lu_r0", 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NORM_V, 0);
    cyc("no_load", 1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, NORM_V, 0);

    // branch beats load-use
    cyc("br_lu", 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FLUSH_V, 0);

    // mul/div: issue, 3 stalls, done on 4th wait cycle (load-use ignored there)
    cyc("md_issue", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, NORM_V, 1);
    for (int i = 0; i < 3; i++) idle("md_wait", STALL_V, 1);
    cyc("md_done", 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, NORM_V, 0);
    idle("md_after", NORM_V, 0);

    // back-to-back: done+start restarts the wait counter
    cyc("b2b_issue", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, NORM_V, 1);
    idle("b2b_w0", STALL_V, 1);
    idle("b2b_w1", STALL_V, 1);
    cyc("b2b_done", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, NORM_V, 1);
    for (int i = 0; i < 3; i++) idle("b2b_w2", STALL_V, 1);
    // branch in wait aborts the mul/div
    cyc("md_abort", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, ABORT_V, 0);
    idle("abort_after", NORM_V, 0);

    // timeout: four stalls then forced release with sticky error
    cyc("to_issue", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, NORM_V, 1);
    for (int i = 0; i < 3; i++) idle("to_wait", STALL_V, 1);
    exp_err = 1;
    idle("to_last", STALL_V, 0);
    for (int i = 0; i < 3; i++) idle("to_sticky", NORM_V, 0);

    // asynchronous reset in the middle of a mul/div wait
    cyc("rmd_issue", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, NORM_V, 1);
    idle("rmd_wait", STALL_V, 1);
    #2;
    rst = 1'b1;
    #1;
    exp_state = 0; exp_stall = 0; exp_flush = 0; exp_err = 0;
    check_val("rmd.ctrl", 32'(ctrl_vec()), 32'(RST_V));
    check_regs("rmd");
    @(posedge clk);
    #1;
    check_val("rmd_hold.ctrl", 32'(ctrl_vec()), 32'(RST_V));
    check_regs("rmd_hold");
    rst = 1'b0;
    idle("rmd_release", NORM_V, 0);

    // saturation: 20 load-use stalls with random registers
    for (int i = 0; i < 20; i++) begin
      logic [4:0] r;
      r = 5'($urandom_range(1, 31));
      cyc("sat_lu", 1'b1, r, r, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
          1'b0, 1'b0, 1'b0, STALL_V, 0);
      idle("sat_gap", NORM_V, 0);
    end
    check_val("sat.stall_cnt", 32'(stall_cnt), 32'd15);
    check_val("sb.empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
